// File: rtl/pa_noc_pkg.sv
// Shared NoC router definitions: packet width, port indices and
// arbiter state encoding.
package pa_noc;

    localparam int PACKET_WIDTH     = 32;
    localparam int NUM_ROUTER_PORTS = 5;

    localparam int PORT_NI    = 4;
    localparam int PORT_NORTH = 3;
    localparam int PORT_SOUTH = 2;
    localparam int PORT_EAST  = 1;
    localparam int PORT_WEST  = 0;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_HOLD  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first request strictly after
// i_last_grant, wrapping, via a doubled request vector.
module rr_priority_picker #(
    parameter  int NUM_REQ = 5,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_req
);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] mask;
    logic [2*NUM_REQ-1:0] masked;
    logic                 found;

    // Upper copy of the requests covers the wrap-around search.
    always_comb begin
        dbl_req = {i_req, i_req};
        for (int j = 0; j < 2*NUM_REQ; j++) begin
            mask[j] = (j > int'(i_last_grant));
        end
        masked = dbl_req & mask;
    end

    always_comb begin
        found       = 1'b0;
        o_grant_idx = '0;
        o_grant     = '0;
        for (int j = 0; j < 2*NUM_REQ; j++) begin
            if (masked[j] && !found) begin
                found = 1'b1;
                if (j >= NUM_REQ) begin
                    o_grant_idx = IDX_W'(j - NUM_REQ);
                end else begin
                    o_grant_idx = IDX_W'(j);
                end
            end
        end
        o_any_req = |i_req;
        if (found) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter popping one input FIFO per load into a holding
// register that is presented until the route stage accepts it.
module rr_packet_arbiter #(
    parameter  int NUM_REQ      = pa_noc::NUM_ROUTER_PORTS,
    localparam int PACKET_WIDTH = pa_noc::PACKET_WIDTH,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_fifoHasPacket,
    input  logic [PACKET_WIDTH-1:0] i_fifoReadData [NUM_REQ],
    input  logic                    i_arbiterReady,
    output logic [NUM_REQ-1:0]      o_fifoReadEn,
    output logic [PACKET_WIDTH-1:0] o_packet,
    output logic                    o_packetIsValid,
    output logic [IDX_W-1:0]        o_grantIdx
);

    import pa_noc::arb_state_t;
    import pa_noc::ARB_EMPTY;
    import pa_noc::ARB_HOLD;

    arb_state_t              state_q, state_d;
    logic [PACKET_WIDTH-1:0] packet_q, packet_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;
    logic               load;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req        (i_fifoHasPacket),
        .i_last_grant (last_grant_q),
        .o_grant      (pick_oh),
        .o_grant_idx  (pick_idx),
        .o_any_req    (any_req)
    );

    // No pop during reset: the popped word would be lost.
    always_comb begin
        load = any_req && !i_rst
            && ((state_q == ARB_EMPTY) || i_arbiterReady);
        state_d      = state_q;
        packet_d     = packet_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        if (load) begin
            state_d      = ARB_HOLD;
            packet_d     = i_fifoReadData[pick_idx];
            grant_idx_d  = pick_idx;
            last_grant_d = pick_idx;
        end else if (state_q == ARB_HOLD && i_arbiterReady) begin
            state_d  = ARB_EMPTY;
            packet_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ARB_EMPTY;
            packet_q     <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            packet_q     <= packet_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign o_fifoReadEn    = load ? pick_oh : '0;
    assign o_packet        = packet_q;
    assign o_packetIsValid = (state_q == ARB_HOLD);
    assign o_grantIdx      = grant_idx_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench for rr_packet_arbiter with a queue-based FIFO and
// round-robin reference model.
module tb_rr_packet_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  i_fifoHasPacket;
    logic [31:0] i_fifoReadData [5];
    logic        i_arbiterReady;
    logic [4:0]  o_fifoReadEn;
    logic [31:0] o_packet;
    logic        o_packetIsValid;
    logic [2:0]  o_grantIdx;

    rr_packet_arbiter dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_fifoHasPacket (i_fifoHasPacket),
        .i_fifoReadData  (i_fifoReadData),
        .i_arbiterReady  (i_arbiterReady),
        .o_fifoReadEn    (o_fifoReadEn),
        .o_packet        (o_packet),
        .o_packetIsValid (o_packetIsValid),
        .o_grantIdx      (o_grantIdx)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic [31:0] fq [5][$];
    exp_t        sbq [$];
    int          ref_last;
    bit          ref_hold;
    logic [4:0]  exp_ren;
    bit          mon_en;
    int          total;
    int          bad;

    function automatic void chk(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endfunction

    // Round-robin rule: first requester strictly after the last grant.
    function automatic int pick(input logic [4:0] req, input int last);
        for (int k = 1; k <= 5; k++) begin
            if (req[(last + k) % 5]) return (last + k) % 5;
        end
        return -1;
    endfunction

    task automatic push(input int n, input logic [31:0] d);
        fq[n].push_back(d);
    endtask

    task automatic drive(input bit rdy);
        logic [4:0] req;
        int s;
        for (int n = 0; n < 5; n++) begin
            req[n] = (fq[n].size() != 0);
            i_fifoReadData[n] = req[n] ? fq[n][0] : $urandom;
        end
        i_fifoHasPacket = req;
        i_arbiterReady  = rdy;
        exp_ren = '0;
        if (req != 0 && (!ref_hold || rdy)) begin
            s = pick(req, ref_last);
            exp_ren[s] = 1'b1;
            sbq.push_back({3'(s), fq[s][0]});
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (exp_ren != 0) begin
            for (int n = 0; n < 5; n++) begin
                if (exp_ren[n]) begin
                    void'(fq[n].pop_front());
                    ref_last = n;
                end
            end
            ref_hold = 1'b1;
        end else if (ref_hold && i_arbiterReady) begin
            ref_hold = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        i_rst = 1'b1;
        i_fifoHasPacket = '0;
        i_arbiterReady = 1'b0;
        exp_ren = '0;
        tick();
        tick();
        i_rst = 1'b0;
        ref_hold = 1'b0;
        ref_last = 4;
        sbq.delete();
        for (int n = 0; n < 5; n++) fq[n].delete();
        mon_en = 1'b1;
        chk("rst_pkt", 64'(o_packet), 64'h0);
        chk("rst_vld", 64'(o_packetIsValid), 64'h0);
        chk("rst_idx", 64'(o_grantIdx), 64'h0);
        chk("rst_ren", 64'(o_fifoReadEn), 64'h0);
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            chk("ren", 64'(o_fifoReadEn), 64'(exp_ren));
            chk("valid", 64'(o_packetIsValid), 64'(ref_hold));
            if (!ref_hold) chk("idle_pkt", 64'(o_packet), 64'h0);
            if (o_packetIsValid) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty", 64'(o_packetIsValid), 64'h0);
                end else begin
                    chk("sb_idx", 64'(o_grantIdx), 64'(sbq[0].idx));
                    chk("sb_data", 64'(o_packet), 64'(sbq[0].data));
                    if (i_arbiterReady) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        mon_en = 1'b0;
        ref_hold = 1'b0;
        ref_last = 4;
        exp_ren = '0;
        for (int n = 0; n < 5; n++) i_fifoReadData[n] = '0;

        // single request from South
        do_reset();
        push(2, 32'hA5);
        drive(1'b1);
        tick();
        chk("t1_pkt", 64'(o_packet), 64'hA5);
        chk("t1_idx", 64'(o_grantIdx), 64'd2);
        drive(1'b1);
        tick();

        // all requesting, ready high: 0,1,2,3,4,0
        do_reset();
        for (int n = 0; n < 5; n++)
            for (int k = 0; k < 3; k++) push(n, $urandom);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1);
            tick();
            chk("t2_order", 64'(o_grantIdx), 64'(k % 5));
        end

        // hold for 4 cycles with ready low while requests change
        for (int k = 0; k < 4; k++) begin
            push($urandom_range(0, 4), $urandom);
            drive(1'b0);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            drive(1'b1);
            tick();
        end

        // wrap: lastGrant = 3, requests 01001 -> 0 then 3
        do_reset();
        push(3, $urandom);
        drive(1'b1);
        tick();
        push(0, $urandom);
        push(3, $urandom);
        drive(1'b1);
        tick();
        chk("t4_wrap", 64'(o_grantIdx), 64'd0);
        drive(1'b1);
        tick();
        chk("t4_next", 64'(o_grantIdx), 64'd3);
        drive(1'b1);
        tick();

        // sole requester NI, three packets back-to-back
        do_reset();
        for (int k = 0; k < 3; k++) push(4, 32'h100 + 32'(k));
        for (int k = 0; k < 3; k++) begin
            drive(1'b1);
            tick();
            chk("t5_idx", 64'(o_grantIdx), 64'd4);
            chk("t5_pkt", 64'(o_packet), 64'h100 + 64'(k));
        end
        drive(1'b1);
        tick();
        chk("t5_drop", 64'(o_packetIsValid), 64'h0);
        chk("t5_zero", 64'(o_packet), 64'h0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 5; n++)
                if ($urandom_range(0, 3) == 0) push(n, $urandom);
            drive($urandom_range(0, 2) != 0);
            tick();
        end

        // reset while holding, then all request
        if (!ref_hold) begin
            push(1, $urandom);
            drive(1'b1);
            tick();
        end
        chk("t6_held", 64'(o_packetIsValid), 64'h1);
        do_reset();
        for (int n = 0; n < 5; n++) push(n, $urandom);
        drive(1'b1);
        tick();
        chk("t6_first", 64'(o_grantIdx), 64'd0);

        // drain, bounded
        for (int c = 0; c < 200; c++) begin
            drive(1'b1);
            tick();
        end
        chk("drain_vld", 64'(o_packetIsValid), 64'h0);
        chk("drain_sb", 64'(sbq.size()), 64'h0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
Round-robin arbiter that shares a router's single forwarding datapath between its five input FIFOs (NI, North, South, East, West). It selects one non-empty FIFO, pops its head packet into an output holding register, and presents it with a valid flag until the routing logic reports a completed forward. It sits between the input FIFO bank and the XY route/output stage inside the router. Back-to-back forwarding is supported at one packet per cycle.

Parameters:
NUM_REQ, 5, number of requesting FIFOs; index 4 = NI, 3 = North, 2 = South, 1 = East, 0 = West.
PACKET_WIDTH, pa_noc::PACKET_WIDTH, packet width in bits. Localparam, not overridable.
IDX_W, $clog2(NUM_REQ), grant index width. Localparam.

Ports:
i_clk  input  1  clock; one clock domain. Reset is synchronous and active-high.
i_rst  input  1  synchronous active-high reset, sampled on posedge i_clk.
i_fifoHasPacket  input  NUM_REQ  bit n high = FIFO n non-empty.
i_fifoReadData  input  NUM_REQ x PACKET_WIDTH  head word of each FIFO (first-word fall-through).
i_arbiterReady  input  1  high = held packet forwarded this cycle.
o_fifoReadEn  output  NUM_REQ  one-hot, one-cycle pop strobe.
o_packet  output  PACKET_WIDTH  held packet.
o_packetIsValid  output  1  o_packet is valid.
o_grantIdx  output  IDX_W  index of the FIFO that supplied o_packet.

Behaviour:
- Reset values: o_packet = 0, o_packetIsValid = 0, o_grantIdx = 0, o_fifoReadEn = 0. lastGrant = NUM_REQ-1, so index 0 has top priority after reset.
- States: EMPTY (no packet held) and HOLD (packet held, o_packetIsValid = 1).
- Load condition: (state == EMPTY) or (state == HOLD and i_arbiterReady), together with |i_fifoHasPacket.
- On a load:
  - sel = first set bit of i_fifoHasPacket, searching from lastGrant+1 upward and wrapping modulo NUM_REQ.
  - o_fifoReadEn[sel] = 1 combinationally in the same cycle.
  - Next edge: o_packet <= i_fifoReadData[sel], o_grantIdx <= sel, lastGrant <= sel, state <= HOLD.
- In HOLD with i_arbiterReady and no requests: next state is EMPTY, o_packetIsValid <= 0, o_packet <= 0.
- In HOLD without i_arbiterReady: all registers hold and o_fifoReadEn = 0. The packet and valid flag are stable until accepted.
- In EMPTY: i_arbiterReady is ignored.
- o_fifoReadEn is never asserted for a FIFO whose i_fifoHasPacket bit is 0. At most one bit is ever set.
- lastGrant updates only on a load; a sole requester is re-granted every cycle.
- Fairness: with all requests held high, grants rotate 0,1,2,3,4,0,… Any continuously requesting FIFO is served within NUM_REQ loads.
- The FIFO empty flag is registered, so i_fifoHasPacket already reflects a pop one cycle later. Back-to-back loads from the same FIFO are legal.
- Latency: request visible -> o_packetIsValid high on the next edge (1 cycle). Steady-state throughput is 1 packet/cycle while i_arbiterReady = 1.
- Reset mid-operation: the held packet is discarded (its FIFO was already popped), state goes to EMPTY, and lastGrant goes to NUM_REQ-1.

Decomposition:
- pa_noc (shared package):
  - existing PACKET_WIDTH
  - NUM_ROUTER_PORTS = 5
  - port index constants PORT_NI = 4, PORT_NORTH = 3, PORT_SOUTH = 2, PORT_EAST = 1, PORT_WEST = 0
  - state enum arb_state_t {ARB_EMPTY, ARB_HOLD}
- Sub-module rr_priority_picker (combinational).
  - Inputs: request vector and lastGrant.
  - Outputs: one-hot grant, grant index, any-request flag.
  - Implementation: double-width masked find-first-set.
  - Also reusable by future output-port allocators.

Test Plan:
1. Reset, then i_fifoHasPacket = 5'b00100 with data[2] = 0xA5 -> o_fifoReadEn = 5'b00100 for 1 cycle; next cycle o_packet = 0xA5, o_packetIsValid = 1, o_grantIdx = 2.
2. All five requests held, i_arbiterReady = 1 constantly -> grant order 0,1,2,3,4,0; one pop per cycle; o_packetIsValid stays 1.
3. Packet held with i_arbiterReady = 0 for 4 cycles while requests change -> o_packet, o_grantIdx and o_packetIsValid unchanged; o_fifoReadEn = 0 throughout.
4. lastGrant = 3 and requests = 5'b01001 -> next grant is 0 (wrap, skipping 3), then 3.
5. Single request 5'b10000 with 3 packets and ready high -> three consecutive pops from index 4, then o_packetIsValid falls to 0 and o_packet to 0 when the FIFO empties.
6. Assert i_rst while in HOLD -> next cycle all outputs 0; after release with requests 5'b11111, first grant is index 0.
